// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-lite master and its bus interface.
// The package holds the master state encoding, the OKAY response code and the default bus widths.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    localparam logic [2:0] RESP_OKAY = 3'b000;

    localparam int DEF_DATA_LEN  = 32;
    localparam int DEF_STORB_LEN = DEF_DATA_LEN / 8;
    localparam int DEF_ADDR_LEN  = 32;
    localparam int DEF_TIMEOUT   = 255;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite style bus between the master and the sram responder.
// It carries the AW, W, B, AR and R channels, with master and slave modports.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int DATA_LEN  = DEF_DATA_LEN,
    parameter int STORB_LEN = DEF_STORB_LEN,
    parameter int ADDR_LEN  = DEF_ADDR_LEN
);
    logic                 awvalid;
    logic                 awready;
    logic [ADDR_LEN-1:0]  waddr;
    logic                 wvalid;
    logic                 wready;
    logic [DATA_LEN-1:0]  wdata;
    logic [STORB_LEN-1:0] wstrob;
    logic                 bvalid;
    logic                 bready;
    logic [2:0]           bresp;
    logic                 arvalid;
    logic                 arready;
    logic [ADDR_LEN-1:0]  raddr;
    logic                 rvalid;
    logic                 rready;
    logic [DATA_LEN-1:0]  rdata;
    logic [2:0]           rresp;

    modport master (
        output awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: one CPU load/store becomes AR/R or AW/W/B handshakes.
// Define AXI_MASTER_TIMEOUT_EN to add the R/B timeout counter and to drain late responses while idle.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int DATA_LEN       = DEF_DATA_LEN,
    parameter int STORB_LEN      = DEF_STORB_LEN,
    parameter int ADDR_LEN       = DEF_ADDR_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [ADDR_LEN-1:0]  req_addr,
    input  logic [DATA_LEN-1:0]  req_wdata,
    input  logic [STORB_LEN-1:0] req_wstrob,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_LEN-1:0]  resp_rdata,
    output logic                 resp_err,
    axi_lite_if.master           bus
);

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_fin;
    logic   w_fin;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    // AW and W may complete in the same cycle or in any order.
    assign aw_fin    = aw_done | (bus.awvalid & bus.awready);
    assign w_fin     = w_done  | (bus.wvalid  & bus.wready);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            bus.awvalid <= 1'b0;
            bus.wvalid  <= 1'b0;
            bus.bready  <= 1'b0;
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b0;
            bus.waddr   <= '0;
            bus.raddr   <= '0;
            bus.wdata   <= '0;
            bus.wstrob  <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef AXI_MASTER_TIMEOUT_EN
                    bus.rready <= 1'b1;
                    bus.bready <= 1'b1;
`endif
                    if (req_valid) begin
                        bus.raddr  <= req_addr;
                        bus.waddr  <= req_addr;
                        bus.wdata  <= req_wdata;
                        bus.wstrob <= req_wstrob;
                        bus.rready <= 1'b0;
                        bus.bready <= 1'b0;
                        if (req_wen) begin
                            bus.awvalid <= 1'b1;
                            bus.wvalid  <= 1'b1;
                            state       <= WR_REQ;
                        end else begin
                            bus.arvalid <= 1'b1;
                            state       <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= RD_DATA;
`ifdef AXI_MASTER_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                RD_DATA: begin
                    if (bus.rvalid) begin
                        resp_rdata <= bus.rdata;
                        resp_err   <= (bus.rresp != RESP_OKAY);
                        bus.rready <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
`ifdef AXI_MASTER_TIMEOUT_EN
                    end else if (to_hit) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        bus.rready <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                WR_REQ: begin
                    if (bus.awvalid && bus.awready) begin
                        bus.awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (bus.wvalid && bus.wready) begin
                        bus.wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        bus.bready <= 1'b1;
                        state      <= WR_RESP;
`ifdef AXI_MASTER_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                WR_RESP: begin
                    if (bus.bvalid) begin
                        resp_rdata <= '0;
                        resp_err   <= (bus.bresp != RESP_OKAY);
                        bus.bready <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
`ifdef AXI_MASTER_TIMEOUT_EN
                    end else if (to_hit) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        bus.bready <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: read, write with late AWREADY, error hold, reset abort,
// and (with AXI_MASTER_TIMEOUT_EN) the R timeout and idle drain.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrob;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad = 0;
    int aw_hs = 0;
    int w_hs = 0;
    int b_hs = 0;

    axi_lite_if #(.DATA_LEN(32), .STORB_LEN(4), .ADDR_LEN(32)) bus ();

    axi_lite_master #(
        .DATA_LEN(32), .STORB_LEN(4), .ADDR_LEN(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrob(req_wstrob),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.awvalid && bus.awready) aw_hs++;
        if (bus.wvalid && bus.wready) w_hs++;
        if (bus.bvalid && bus.bready) b_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One-cycle request pulse; the master latches it on the next edge.
    task automatic applyStimulus(input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        checkOutput("req_ready_before_req", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wstrob = strb;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic finishResp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("resp_valid_after_hs", 32'(resp_valid), 32'd0);
        checkOutput("req_ready_after_hs", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrob = '0;
        resp_ready = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 3'b000;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 3'b000;
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_valids", {28'd0, bus.awvalid, bus.wvalid, bus.arvalid, resp_valid}, 32'd0);
        checkOutput("rst_readies", {30'd0, bus.rready, bus.bready}, 32'd0);
        checkOutput("rst_rdata_err", resp_rdata | 32'(resp_err), 32'd0);
        rst = 1'b0;
        tick();

        // Read with zero-wait AR and RVALID one cycle after the AR handshake.
        bus.arready = 1'b1;
        applyStimulus(1'b0, 32'h8000_0000, 32'h0, 4'h0);
        checkOutput("rd_arvalid", 32'(bus.arvalid), 32'd1);
        checkOutput("rd_raddr", bus.raddr, 32'h8000_0000);
        checkOutput("rd_req_ready_busy", 32'(req_ready), 32'd0);
        tick();
        checkOutput("rd_arvalid_drop", 32'(bus.arvalid), 32'd0);
        checkOutput("rd_rready", 32'(bus.rready), 32'd1);
        bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 3'b000;
        tick();
        bus.rvalid = 1'b0; bus.rdata = '0;
        checkOutput("rd_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        checkOutput("rd_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rd_rready_drop", 32'(bus.rready), 32'd0);
        finishResp();

        // Write: WREADY immediate, AWREADY two cycles late.
        aw_hs = 0; w_hs = 0; b_hs = 0;
        bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b1;
        applyStimulus(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
        checkOutput("wr_valids", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        checkOutput("wr_waddr", bus.waddr, 32'h8000_0010);
        checkOutput("wr_wdata", bus.wdata, 32'h1234_5678);
        checkOutput("wr_wstrob", 32'(bus.wstrob), 32'h3);
        tick();
        bus.wready = 1'b0;
        checkOutput("wr_w_done", {30'd0, bus.awvalid, bus.wvalid}, 32'd2);
        tick();
        checkOutput("wr_aw_held", {30'd0, bus.awvalid, bus.bready}, 32'd2);
        checkOutput("wr_waddr_stable", bus.waddr, 32'h8000_0010);
        bus.awready = 1'b1;
        tick();
        bus.awready = 1'b0;
        checkOutput("wr_aw_drop_bready", {30'd0, bus.awvalid, bus.bready}, 32'd1);
        checkOutput("wr_aw_hs", 32'(aw_hs), 32'd1);
        checkOutput("wr_w_hs", 32'(w_hs), 32'd1);
        bus.bvalid = 1'b1; bus.bresp = 3'b000;
        tick();
        bus.bvalid = 1'b0;
        checkOutput("wr_b_hs", 32'(b_hs), 32'd1);
        checkOutput("wr_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("wr_resp_err", 32'(resp_err), 32'd0);
        checkOutput("wr_resp_rdata", resp_rdata, 32'd0);
        finishResp();

        // Error read with the CPU stalling the response for four cycles.
        bus.arready = 1'b1;
        applyStimulus(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        tick();
        bus.rvalid = 1'b1; bus.rdata = 32'h0000_0055; bus.rresp = 3'b010;
        tick();
        bus.rvalid = 1'b0; bus.rresp = 3'b000;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("err_hold_valid%0d", i), 32'(resp_valid), 32'd1);
            checkOutput($sformatf("err_hold_err%0d", i), 32'(resp_err), 32'd1);
            checkOutput($sformatf("err_hold_rdata%0d", i), resp_rdata, 32'h0000_0055);
            tick();
        end
        finishResp();

        // Reset while the write address is still pending.
        bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        applyStimulus(1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF);
        checkOutput("abort_awvalid", 32'(bus.awvalid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_valids", {28'd0, bus.awvalid, bus.wvalid, bus.arvalid, resp_valid}, 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_bready", 32'(bus.bready), 32'd0);

`ifndef AXI_MASTER_TIMEOUT_EN
        // A stray B response while idle must be ignored.
        bus.bvalid = 1'b1;
        tick();
        tick();
        checkOutput("stray_bready", 32'(bus.bready), 32'd0);
        checkOutput("stray_resp_valid", 32'(resp_valid), 32'd0);
        bus.bvalid = 1'b0;
`else
        // Slave never answers the read: timeout fires after eight RD_DATA cycles.
        tick();
        bus.arready = 1'b1;
        applyStimulus(1'b0, 32'h8000_0040, 32'h0, 4'h0);
        tick();
        bus.arready = 1'b0;
        checkOutput("to_rready", 32'(bus.rready), 32'd1);
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("to_cycles", 32'(n), 32'd8);
        checkOutput("to_resp_err", 32'(resp_err), 32'd1);
        checkOutput("to_resp_rdata", resp_rdata, 32'd0);
        finishResp();
        tick();
        checkOutput("drain_rready", 32'(bus.rready), 32'd1);
        bus.rvalid = 1'b1; bus.rdata = 32'hBAD0_BAD0;
        tick();
        bus.rvalid = 1'b0;
        tick();
        checkOutput("drain_no_resp", 32'(resp_valid), 32'd0);
        checkOutput("drain_req_ready", 32'(req_ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
